dir_input_conditioner: RTL and testbench



---
 rtl/dir_input_conditioner.sv | 141 ++++++++++++++
 tb/tb_dir_input_conditioner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dir_input_conditioner.sv
// Joystick direction conditioner: per-bit 2-flop synchroniser, optional
// debounce, per-axis opposing-direction (SOCD) resolution, registered
// direction output with change pulse, and a history register holding the
// last non-diagonal output for the downstream diagonal prediction stage.
// Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right.
module dir_input_conditioner #(
    parameter int DEBOUNCE_COUNT = 0,
    parameter int SOCD_MODE      = 1
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [3:0] raw_dir,
    output logic [3:0] dir_out,
    output logic [3:0] oldp_out,
    output logic       dir_change
);

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] stable;
    logic [3:0] prev_q;
    logic [3:0] rise;
    logic       last_v_q, last_v_d;   // 1 = down pressed last, 0 = up
    logic       last_h_q, last_h_d;   // 1 = left pressed last, 0 = right
    logic [3:0] socd;
    logic [3:0] dir_q, oldp_q;
    logic       chg_q;
    logic       diag;

    // Two-flop synchroniser for the asynchronous raw directions
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_dir;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_COUNT == 0) begin : g_bypass
            logic unused_ce;
            assign unused_ce = ce;
            assign stable    = sync2_q;
        end else begin : g_debounce
            localparam int            CW   = $clog2(DEBOUNCE_COUNT + 1);
            localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_COUNT);

            logic [CW-1:0] cnt_q [0:3];
            logic [CW-1:0] cnt_d [0:3];
            logic [3:0]    stable_q, stable_d;

            // Per-bit disagreement counter; flips the stable bit on terminal count
            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < 4; i++) begin
                    cnt_d[i] = cnt_q[i];
                    if (ce) begin
                        if (sync2_q[i] != stable_q[i]) begin
                            if ((cnt_q[i] + CW'(1)) == TERM) begin
                                stable_d[i] = sync2_q[i];
                                cnt_d[i]    = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CW'(1);
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                end
            end

            // Debounce state registers
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= '0;
                    for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
                end else begin
                    stable_q <= stable_d;
                    for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
                end
            end

            assign stable = stable_q;
        end
    endgenerate

    assign rise = stable & ~prev_q;

    // SOCD resolution; the updated "last" value is used so a fresh press wins
    // in the same cycle it appears instead of one cycle later
    always_comb begin
        last_v_d = last_v_q;
        last_h_d = last_h_q;
        if (rise[3] ^ rise[2]) last_v_d = rise[2];
        if (rise[1] ^ rise[0]) last_h_d = rise[1];

        socd = stable;
        if (SOCD_MODE == 1) begin
            if (stable[3] && stable[2]) socd[3:2] = 2'b00;
            if (stable[1] && stable[0]) socd[1:0] = 2'b00;
        end else if (SOCD_MODE == 2) begin
            if (stable[3] && stable[2]) socd[3:2] = last_v_d ? 2'b01 : 2'b10;
            if (stable[1] && stable[0]) socd[1:0] = last_h_d ? 2'b10 : 2'b01;
        end
    end

    // Last-pressed tracking for the mode where the most recent press wins
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            prev_q   <= '0;
            last_v_q <= 1'b0;
            last_h_q <= 1'b0;
        end else begin
            prev_q   <= stable;
            last_v_q <= last_v_d;
            last_h_q <= last_h_d;
        end
    end

    assign diag = (|dir_q[3:2]) && (|dir_q[1:0]);

    // Output register, change pulse and non-diagonal history
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dir_q  <= '0;
            chg_q  <= 1'b0;
            oldp_q <= '0;
        end else begin
            dir_q <= socd;
            chg_q <= (socd != dir_q);
            if (!diag) oldp_q <= dir_q;
        end
    end

    assign dir_out    = dir_q;
    assign oldp_out   = oldp_q;
    assign dir_change = chg_q;

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Bench for dir_input_conditioner. Three instances:
//   u0: no debounce, SOCD neutral      (latency, history, neutral SOCD)
//   u4: debounce of 4, SOCD neutral    (glitch filter, async reset)
//   u2: no debounce, last-pressed SOCD
// Expected dir_out values are queued when stimulus is applied; a monitor per
// instance pops and compares on every dir_change pulse.
module tb_dir_input_conditioner;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce;
    logic [3:0] raw0, raw4, raw2;
    logic [3:0] u0_dir, u0_oldp, u4_dir, u4_oldp, u2_dir, u2_oldp;
    logic       u0_chg, u4_chg, u2_chg;

    logic [3:0] q0[$];
    logic [3:0] q4[$];
    logic [3:0] q2[$];

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    dir_input_conditioner #(.DEBOUNCE_COUNT(0), .SOCD_MODE(1)) u0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .raw_dir(raw0),
        .dir_out(u0_dir), .oldp_out(u0_oldp), .dir_change(u0_chg));

    dir_input_conditioner #(.DEBOUNCE_COUNT(4), .SOCD_MODE(1)) u4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .raw_dir(raw4),
        .dir_out(u4_dir), .oldp_out(u4_oldp), .dir_change(u4_chg));

    dir_input_conditioner #(.DEBOUNCE_COUNT(0), .SOCD_MODE(2)) u2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .raw_dir(raw2),
        .dir_out(u2_dir), .oldp_out(u2_oldp), .dir_change(u2_chg));

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, inout logic [3:0] q[$], input logic [3:0] act);
        logic [3:0] exp;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected change got=%b exp=none t=%0t", name, act, $time);
        end else begin
            exp = q.pop_front();
            chk(name, act, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk_sys) begin
        if (reset_n === 1'b1) begin
            if (u0_chg) sb_pop("sb_u0", q0, u0_dir);
            if (u4_chg) sb_pop("sb_u4", q4, u4_dir);
            if (u2_chg) sb_pop("sb_u2", q2, u2_dir);
        end
    end

    task automatic slot();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_neg(input int k);
        repeat (k) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        raw0 = '0; raw4 = '0; raw2 = '0; ce = 1'b1;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_u0_dir",  u0_dir,  4'b0000);
        chk("rst_u0_oldp", u0_oldp, 4'b0000);
        chk("rst_u0_chg",  {3'b0, u0_chg}, 4'b0000);
        chk("rst_u4_dir",  u4_dir,  4'b0000);
        chk("rst_u2_dir",  u2_dir,  4'b0000);
        slot();
        reset_n = 1'b1;

        // Latency without debounce
        slot();
        q0.push_back(4'b0001); raw0 = 4'b0001;
        wait_neg(2);
        chk("lat_e2_dir", u0_dir, 4'b0000);
        wait_neg(1);
        chk("lat_e3_dir", u0_dir, 4'b0001);
        chk("lat_e3_chg", {3'b0, u0_chg}, 4'b0001);
        chk("lat_e3_oldp", u0_oldp, 4'b0000);
        wait_neg(1);
        chk("lat_e4_oldp", u0_oldp, 4'b0001);
        chk("lat_e4_chg", {3'b0, u0_chg}, 4'b0000);

        // Diagonal history
        slot();
        q0.push_back(4'b1001); raw0 = 4'b1001;
        wait_neg(3);
        chk("diag_dir", u0_dir, 4'b1001);
        chk("diag_oldp_a", u0_oldp, 4'b0001);
        wait_neg(3);
        chk("diag_oldp_b", u0_oldp, 4'b0001);
        slot();
        q0.push_back(4'b1000); raw0 = 4'b1000;
        wait_neg(3);
        chk("rel_dir", u0_dir, 4'b1000);
        chk("rel_oldp_lag", u0_oldp, 4'b0001);
        wait_neg(1);
        chk("rel_oldp", u0_oldp, 4'b1000);

        // Neutral SOCD
        slot();
        q0.push_back(4'b0000); raw0 = 4'b0011;
        wait_neg(4);
        chk("socd1_lr", u0_dir, 4'b0000);
        slot();
        raw0 = 4'b1100;
        wait_neg(4);
        chk("socd1_ud", u0_dir, 4'b0000);
        slot();
        q0.push_back(4'b0010); raw0 = 4'b1110;
        wait_neg(4);
        chk("socd1_udl", u0_dir, 4'b0010);
        slot();
        q0.push_back(4'b0000); raw0 = 4'b0000;
        wait_neg(4);
        chk("sb_u0_drain", 4'(q0.size()), 4'd0);

        // Last-pressed SOCD
        slot();
        q2.push_back(4'b0010); raw2 = 4'b0010;
        wait_neg(4);
        slot();
        q2.push_back(4'b0001); raw2 = 4'b0011;
        wait_neg(4);
        chk("socd2_right_wins", u2_dir, 4'b0001);
        slot();
        q2.push_back(4'b0010); raw2 = 4'b0010;
        wait_neg(4);
        chk("socd2_release", u2_dir, 4'b0010);
        slot();
        q2.push_back(4'b0000); raw2 = 4'b0000;
        wait_neg(4);
        slot();
        q2.push_back(4'b1000); raw2 = 4'b1100;
        wait_neg(4);
        chk("socd2_tie_up", u2_dir, 4'b1000);
        slot();
        q2.push_back(4'b0000); raw2 = 4'b0000;
        wait_neg(4);
        chk("sb_u2_drain", 4'(q2.size()), 4'd0);

        // Debounce: a 3-clock glitch is filtered
        slot();
        raw4 = 4'b1000;
        repeat (3) @(posedge clk_sys);
        #1 raw4 = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            chk("deb_glitch", u4_dir, 4'b0000);
        end

        // Debounce: sustained press reaches dir_out on edge 7
        slot();
        q4.push_back(4'b1000); raw4 = 4'b1000;
        wait_neg(6);
        chk("deb_e6", u4_dir, 4'b0000);
        wait_neg(1);
        chk("deb_e7", u4_dir, 4'b1000);

        slot();
        q4.push_back(4'b1010); raw4 = 4'b1010;
        wait_neg(8);
        chk("deb_diag_dir", u4_dir, 4'b1010);
        chk("deb_diag_oldp", u4_oldp, 4'b1000);

        // Async reset while diagonal is held and a counter is mid-count
        slot();
        raw4 = 4'b1011;
        repeat (3) @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_dir", u4_dir, 4'b0000);
        chk("arst_oldp", u4_oldp, 4'b0000);
        chk("arst_chg", {3'b0, u4_chg}, 4'b0000);
        @(posedge clk_sys);
        #2;
        q4.push_back(4'b1000);
        reset_n = 1'b1;
        wait_neg(6);
        chk("arst_e6", u4_dir, 4'b0000);
        wait_neg(1);
        chk("arst_e7", u4_dir, 4'b1000);
        wait_neg(1);
        chk("arst_e8_oldp", u4_oldp, 4'b1000);
        slot();
        q4.push_back(4'b0000); raw4 = 4'b0000;
        wait_neg(12);
        chk("sb_u4_drain", 4'(q4.size()), 4'd0);
        chk("sb_u0_final", 4'(q0.size()), 4'd0);
        chk("sb_u2_final", 4'(q2.size()), 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
